pipe_collision_controller: RTL

Downstream consumer of the box register's `y_coordinate`. It owns the game-level state (idle / playing / game over) and scrolls two pipe obstacles leftward one pixel per game tick. It checks the box against the pipes, floor and ceiling every tick, and keeps the score. Its outputs feed the VGA draw logic and the HEX score display.

---
 rtl/pipe_collision_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_collision_controller.sv
// Game-level controller: idle/playing/game-over FSM, two scrolling pipes with
// LFSR-chosen gaps, box-vs-pipe/floor/ceiling collision detection and scoring.
module pipe_collision_controller #(
   parameter int SCREEN_W = 160,
   parameter int BOX_X    = 20,
   parameter int BOX_SIZE = 4,
   parameter int PIPE_W   = 8,
   parameter int GAP_H    = 32,
   parameter int FLOOR_Y  = 116
) (
   input  logic       game_tick_clock,
   input  logic       resetn,
   input  logic       tap,
   input  logic [6:0] y_coordinate,
   output logic [7:0] pipe0_x,
   output logic [7:0] pipe1_x,
   output logic [6:0] pipe0_gap_y,
   output logic [6:0] pipe1_gap_y,
   output logic [7:0] score,
   output logic [1:0] game_state,
   output logic       game_over
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PLAYING   = 2'd1,
      ST_GAME_OVER = 2'd2
   } state_t;

   localparam logic [7:0] PIPE0_X_INIT = 8'(SCREEN_W / 2);
   localparam logic [7:0] PIPE1_X_INIT = 8'(SCREEN_W - 1);
   localparam logic [7:0] WRAP_X       = 8'(SCREEN_W - 1);
   localparam logic [6:0] GAP_INIT     = 7'd40;
   localparam logic [6:0] LFSR_SEED    = 7'h5A;
   localparam logic [7:0] SCORE_X      = 8'(BOX_X - PIPE_W);

   state_t     state_r;
   logic [6:0] lfsr_r;

   logic       pipe0_hit_s;
   logic       pipe1_hit_s;
   logic       floor_hit_s;
   logic       ceil_hit_s;
   logic       hit_s;
   logic [6:0] new_gap_s;
   logic [8:0] score_sum_s;
   logic [7:0] score_next_s;
   logic [7:0] pipe0_x_next_s;
   logic [7:0] pipe1_x_next_s;

   // x^7 + x^6 + 1 Fibonacci step.
   function automatic logic [6:0] lfsr_next(input logic [6:0] v);
      return {v[5:0], v[6] ^ v[5]};
   endfunction

   // Pipe x after one scroll step, wrapping from 0 to the right edge.
   function automatic logic [7:0] pipe_step(input logic [7:0] x);
      logic [7:0] r;
      if (x == 8'd0) begin
         r = WRAP_X;
      end else begin
         r = x - 8'd1;
      end
      return r;
   endfunction

   // Box collides with a pipe when they overlap horizontally and the box is not fully inside the gap.
   function automatic logic pipe_collides(input logic [7:0] x, input logic [6:0] gap, input logic [6:0] y);
      logic [8:0] x9;
      logic [8:0] g9;
      logic [8:0] y9;
      logic       h_ovl;
      logic       v_miss;
      x9     = {1'b0, x};
      g9     = {2'b00, gap};
      y9     = {2'b00, y};
      h_ovl  = (x9 <= 9'(BOX_X + BOX_SIZE - 1)) && ((x9 + 9'(PIPE_W - 1)) >= 9'(BOX_X));
      v_miss = (y9 < g9) || ((y9 + 9'(BOX_SIZE)) > (g9 + 9'(GAP_H)));
      return h_ovl && v_miss;
   endfunction

   // Collision detection on the current registered pipes and box row.
   always_comb begin
      pipe0_hit_s = pipe_collides(pipe0_x, pipe0_gap_y, y_coordinate);
      pipe1_hit_s = pipe_collides(pipe1_x, pipe1_gap_y, y_coordinate);
      floor_hit_s = ({2'b00, y_coordinate} + 9'(BOX_SIZE)) > 9'(FLOOR_Y);
      ceil_hit_s  = (y_coordinate == 7'd0);
      hit_s       = pipe0_hit_s || pipe1_hit_s || floor_hit_s || ceil_hit_s;
   end

   // Next pipe positions, replacement gap and saturating score increment.
   always_comb begin
      pipe0_x_next_s = pipe_step(pipe0_x);
      pipe1_x_next_s = pipe_step(pipe1_x);
      new_gap_s      = 7'd8 + {1'b0, lfsr_r[5:0]};
      score_sum_s    = {1'b0, score}
                     + {8'd0, (pipe0_x == SCORE_X)}
                     + {8'd0, (pipe1_x == SCORE_X)};
      if (score_sum_s[8]) begin
         score_next_s = 8'hFF;
      end else begin
         score_next_s = score_sum_s[7:0];
      end
   end

   // Gap generator free-runs every tick regardless of game state.
   always_ff @(posedge game_tick_clock or negedge resetn) begin
      if (!resetn) begin
         lfsr_r <= LFSR_SEED;
      end else begin
         lfsr_r <= lfsr_next(lfsr_r);
      end
   end

   // Game FSM with registered pipe, score and status outputs.
   always_ff @(posedge game_tick_clock or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         game_over   <= 1'b0;
         pipe0_x     <= PIPE0_X_INIT;
         pipe1_x     <= PIPE1_X_INIT;
         pipe0_gap_y <= GAP_INIT;
         pipe1_gap_y <= GAP_INIT;
         score       <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (tap) begin
                  state_r   <= ST_PLAYING;
                  score     <= 8'd0;
                  game_over <= 1'b0;
               end else begin
                  state_r   <= ST_IDLE;
                  game_over <= 1'b0;
               end
            end
            ST_PLAYING: begin
               if (hit_s) begin
                  state_r   <= ST_GAME_OVER;
                  game_over <= 1'b1;
               end else begin
                  state_r   <= ST_PLAYING;
                  game_over <= 1'b0;
                  pipe0_x   <= pipe0_x_next_s;
                  pipe1_x   <= pipe1_x_next_s;
                  score     <= score_next_s;
                  if (pipe0_x == 8'd0) begin
                     pipe0_gap_y <= new_gap_s;
                  end else begin
                     pipe0_gap_y <= pipe0_gap_y;
                  end
                  if (pipe1_x == 8'd0) begin
                     pipe1_gap_y <= new_gap_s;
                  end else begin
                     pipe1_gap_y <= pipe1_gap_y;
                  end
               end
            end
            ST_GAME_OVER: begin
               if (tap) begin
                  state_r     <= ST_IDLE;
                  game_over   <= 1'b0;
                  pipe0_x     <= PIPE0_X_INIT;
                  pipe1_x     <= PIPE1_X_INIT;
                  pipe0_gap_y <= GAP_INIT;
                  pipe1_gap_y <= GAP_INIT;
               end else begin
                  state_r   <= ST_GAME_OVER;
                  game_over <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               game_over <= 1'b0;
            end
         endcase
      end
   end

   assign game_state = state_r;

endmodule
